// File: rtl/sprite_layer_compositor.sv
// rtl/sprite_layer_compositor.sv - sprite/maze/background pixel compositor with collision and flash
// Two-stage pipeline: stage 1 resolves the sprite priority and maze window, stage 2 picks the final colour.
module sprite_layer_compositor #(
  parameter int          NUM_LAYERS   = 4,
  parameter logic [11:0] TRANS_KEY    = 12'h000,
  parameter int          H_START      = 150,
  parameter int          V_START      = 34,
  parameter int          H_END        = 630,
  parameter int          V_END        = 514,
  parameter int          H_TOTAL      = 800,
  parameter int          V_TOTAL      = 525,
  parameter int          FLASH_FRAMES = 16,
  parameter logic [11:0] FLASH_COLOR  = 12'hFFF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bright,
  input  logic [9:0]                 hCount,
  input  logic [9:0]                 vCount,
  input  logic [NUM_LAYERS-1:0]      layer_fill,
  input  logic [12*NUM_LAYERS-1:0]   layer_color,
  input  logic [11:0]                maze_color,
  input  logic [11:0]                background,
  input  logic                       flash_en,
  output logic [11:0]                rgb,
  output logic [NUM_LAYERS-1:0]      collision,
  output logic                       frame_done
);

  localparam int          CNT_W  = $clog2(FLASH_FRAMES) + 1;
  localparam logic [9:0]  H_LO   = 10'(H_START);
  localparam logic [9:0]  H_HI   = 10'(H_END);
  localparam logic [9:0]  V_LO   = 10'(V_START);
  localparam logic [9:0]  V_HI   = 10'(V_END);
  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_FRAMES - 1);

  logic                  s1_bright_q;
  logic [11:0]           s1_spr_col_q, s1_spr_col_d;
  logic                  s1_spr_vld_q, s1_spr_vld_d;
  logic                  s1_win_q, s1_win_d;
  logic [11:0]           s1_maze_q;
  logic [11:0]           s1_bg_q;
  logic [11:0]           rgb_q, rgb_d;
  logic [NUM_LAYERS-1:0] acc_q, acc_d;
  logic [NUM_LAYERS-1:0] collision_q, collision_d;
  logic                  frame_done_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  phase_q, phase_d;

  logic [NUM_LAYERS-1:0] opaque;
  logic [NUM_LAYERS-1:0] hits;
  logic                  frame_end;

  // Scan from the top layer down so the lowest opaque index is the one left standing.
  always_comb begin
    opaque       = '0;
    s1_spr_col_d = 12'h000;
    s1_spr_vld_d = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      opaque[i] = layer_fill[i] && (layer_color[12*i +: 12] != TRANS_KEY);
      if (opaque[i]) begin
        s1_spr_col_d = layer_color[12*i +: 12];
        s1_spr_vld_d = 1'b1;
      end
    end
    hits = '0;
    for (int i = 1; i < NUM_LAYERS; i++) begin
      hits[i] = bright && opaque[0] && opaque[i];
    end
  end

  assign s1_win_d  = (hCount >= H_LO) && (hCount <= H_HI) &&
                     (vCount >= V_LO) && (vCount <= V_HI);
  assign frame_end = (hCount == H_LAST) && (vCount == V_LAST);

  always_comb begin
    rgb_d = 12'h000;
    if (!s1_bright_q) begin
      rgb_d = 12'h000;
    end else if (s1_spr_vld_q) begin
      rgb_d = s1_spr_col_q;
    end else if (s1_win_q) begin
      rgb_d = phase_q ? FLASH_COLOR : s1_maze_q;
    end else begin
      rgb_d = s1_bg_q;
    end
  end

  // The frame-end cycle's own hits go straight into the reported value.
  always_comb begin
    acc_d       = acc_q | hits;
    collision_d = collision_q;
    if (frame_end) begin
      acc_d       = '0;
      collision_d = acc_q | hits;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!flash_en) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (frame_end) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = !phase_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_bright_q  <= 1'b0;
      s1_spr_col_q <= 12'h000;
      s1_spr_vld_q <= 1'b0;
      s1_win_q     <= 1'b0;
      s1_maze_q    <= 12'h000;
      s1_bg_q      <= 12'h000;
      rgb_q        <= 12'h000;
      acc_q        <= '0;
      collision_q  <= '0;
      frame_done_q <= 1'b0;
      cnt_q        <= '0;
      phase_q      <= 1'b0;
    end else begin
      s1_bright_q  <= bright;
      s1_spr_col_q <= s1_spr_col_d;
      s1_spr_vld_q <= s1_spr_vld_d;
      s1_win_q     <= s1_win_d;
      s1_maze_q    <= maze_color;
      s1_bg_q      <= background;
      rgb_q        <= rgb_d;
      acc_q        <= acc_d;
      collision_q  <= collision_d;
      frame_done_q <= frame_end;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
    end
  end

  assign rgb        = rgb_q;
  assign collision  = collision_q;
  assign frame_done = frame_done_q;

endmodule
